// File: rtl/l2_request_arbiter.sv
// Round-robin N-core request arbiter feeding l2_cache through a one-entry output register.
// Packet layout (MSB..LSB): {valid, core[CORE_ID_WIDTH-1:0], we, addr[31:0], data[31:0]}.
module l2_request_arbiter #(
  parameter int unsigned  NUM_CORES     = 4,
  parameter int unsigned  CORE_ID_WIDTH = 4,
  localparam int unsigned PktWidth      = 2 + CORE_ID_WIDTH + 64
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic [NUM_CORES-1:0][PktWidth-1:0] i_core_l2req_packet,
  output logic [NUM_CORES-1:0]               o_core_l2req_ready,
  output logic [PktWidth-1:0]                o_l2req_packet,
  input  logic                               i_l2req_ready,
  output logic                               o_pc_event_l2_arb_conflict
);

  typedef struct packed {
    logic                     valid;
    logic [CORE_ID_WIDTH-1:0] core;
    logic                     we;
    logic [31:0]              addr;
    logic [31:0]              data;
  } l2req_packet_t;

  l2req_packet_t [NUM_CORES-1:0] w_req;
  l2req_packet_t                 w_sel;
  l2req_packet_t                 w_load_pkt;
  l2req_packet_t                 r_out;
  logic [CORE_ID_WIDTH-1:0]      r_last_grant;
  logic [CORE_ID_WIDTH-1:0]      w_grant_idx;
  logic [NUM_CORES-1:0]          w_grant_oh;
  logic                          w_grant_vld;
  logic                          w_load_en;
  logic                          w_grant;
  logic [4:0]                    w_num_valid;

  assign w_req     = i_core_l2req_packet;
  assign w_load_en = !r_out.valid || i_l2req_ready;

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_grant_oh  = '0;
    w_sel       = '0;
    w_num_valid = '0;
    // Cores above last_grant take priority, then the scan wraps to core 0.
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (!w_grant_vld && w_req[i].valid && (CORE_ID_WIDTH'(i) > r_last_grant)) begin
        w_grant_vld   = 1'b1;
        w_grant_idx   = CORE_ID_WIDTH'(i);
        w_grant_oh[i] = 1'b1;
        w_sel         = w_req[i];
      end
    end
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (!w_grant_vld && w_req[i].valid && (CORE_ID_WIDTH'(i) <= r_last_grant)) begin
        w_grant_vld   = 1'b1;
        w_grant_idx   = CORE_ID_WIDTH'(i);
        w_grant_oh[i] = 1'b1;
        w_sel         = w_req[i];
      end
    end
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      w_num_valid = w_num_valid + 5'(w_req[i].valid);
    end
  end

  always_comb begin
    w_load_pkt      = w_sel;
    w_load_pkt.core = w_grant_idx;
  end

  // Strobes are forced low while reset is held so no core believes it was accepted.
  assign w_grant                    = i_reset && w_load_en && w_grant_vld;
  assign o_core_l2req_ready         = w_grant ? w_grant_oh : '0;
  assign o_pc_event_l2_arb_conflict = w_grant && (w_num_valid >= 5'd2);
  assign o_l2req_packet             = r_out;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_out        <= '0;
      r_last_grant <= CORE_ID_WIDTH'(NUM_CORES - 1);
    end else if (w_load_en) begin
      if (w_grant_vld) begin
        r_out        <= w_load_pkt;
        r_last_grant <= w_grant_idx;
      end else begin
        r_out.valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Randomised and directed bench for l2_request_arbiter against a round-robin reference model.
module tb_l2_request_arbiter;
  localparam int N  = 4;
  localparam int CW = 4;
  localparam int PW = 2 + CW + 64;
  localparam int VB = PW - 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0][PW-1:0] req;
  logic [N-1:0]         rdy_o;
  logic [PW-1:0]        pkt_o;
  logic                 l2rdy;
  logic                 conf;

  always #5 clk = ~clk;

  l2_request_arbiter #(
    .NUM_CORES    (N),
    .CORE_ID_WIDTH(CW)
  ) dut (
    .i_clk                     (clk),
    .i_reset                   (rst_n),
    .i_core_l2req_packet       (req),
    .o_core_l2req_ready        (rdy_o),
    .o_l2req_packet            (pkt_o),
    .i_l2req_ready             (l2rdy),
    .o_pc_event_l2_arb_conflict(conf)
  );

  int            n_checks = 0;
  int            n_errors = 0;
  logic [PW-1:0] m_out;
  int            m_last;
  logic [N-1:0]  e_rdy;
  logic          e_conf;
  logic [N-1:0]  s_rdy;
  logic          s_conf;

  function automatic logic [PW-1:0] mk(input logic v);
    logic [64:0] body;
    body = {1'($urandom), 32'($urandom), 32'($urandom)};
    return {v, CW'($urandom), body};
  endfunction

  function automatic logic [CW-1:0] core_of(input logic [PW-1:0] p);
    return p[PW-2 -: CW];
  endfunction

  // One clock: sample strobes at negedge, predict from the model, advance, settle.
  task automatic do_cycle();
    int g;
    int nv;
    @(negedge clk);
    s_rdy  = rdy_o;
    s_conf = conf;
    g      = -1;
    nv     = 0;
    e_rdy  = '0;
    e_conf = 1'b0;
    if (rst_n) begin
      for (int i = 0; i < N; i++) if (req[i][VB]) nv++;
      if (!m_out[VB] || l2rdy) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (g < 0 && req[c][VB]) g = c;
        end
      end
      if (g >= 0) begin
        e_rdy[g] = 1'b1;
        e_conf   = (nv >= 2);
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      m_out  = '0;
      m_last = N - 1;
    end else if (g >= 0) begin
      m_out              = req[g];
      m_out[PW-2 -: CW]  = CW'(g);
      m_last             = g;
    end else if (!m_out[VB] || l2rdy) begin
      m_out[VB] = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    l2rdy = 1'b1;
    for (int i = 0; i < N; i++) req[i] = mk(1'b1);
    #2;
    repeat (3) begin
      do_cycle();
      n_checks++;
      if (s_rdy !== 4'b0000) begin
        n_errors++; $display("FAIL reset_ready got=%b want=0000", s_rdy);
      end
      n_checks++;
      if (pkt_o[VB] !== 1'b0 || s_conf !== 1'b0) begin
        n_errors++; $display("FAIL reset_out got valid=%b conf=%b want 0/0", pkt_o[VB], s_conf);
      end
    end
    rst_n = 1'b1;
    do_cycle();
    n_checks++;
    if (s_rdy !== 4'b0001) begin
      n_errors++; $display("FAIL reset_first_grant got=%b want=0001", s_rdy);
    end
    n_checks++;
    if (pkt_o[VB] !== 1'b1 || core_of(pkt_o) !== 4'd0 || pkt_o !== m_out) begin
      n_errors++; $display("FAIL reset_first_pkt got=%h want=%h", pkt_o, m_out);
    end
  endtask

  task automatic test_contention();
    int exp_c;
    exp_c = (m_last + 1) % N;
    l2rdy = 1'b1;
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < N; i++) req[i] = mk(1'b1);
      do_cycle();
      n_checks++;
      if (s_rdy !== e_rdy || s_conf !== 1'b1) begin
        n_errors++; $display("FAIL contention_grant got=%b/%b want=%b/1", s_rdy, s_conf, e_rdy);
      end
      n_checks++;
      if (pkt_o[VB] !== 1'b1 || core_of(pkt_o) !== CW'(exp_c) || pkt_o !== m_out) begin
        n_errors++; $display("FAIL contention_order got core=%0d pkt=%h want core=%0d pkt=%h",
                             core_of(pkt_o), pkt_o, exp_c, m_out);
      end
      exp_c = (exp_c + 1) % N;
    end
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] held;
    l2rdy = 1'b1;
    for (int i = 0; i < N; i++) req[i] = mk(i == 2);
    do_cycle();
    n_checks++;
    if (pkt_o[VB] !== 1'b1 || core_of(pkt_o) !== 4'd2) begin
      n_errors++; $display("FAIL bp_load got core=%0d valid=%b want core=2 valid=1",
                           core_of(pkt_o), pkt_o[VB]);
    end
    held  = m_out;
    l2rdy = 1'b0;
    for (int i = 0; i < N; i++) req[i] = mk(1'b1);
    repeat (5) begin
      do_cycle();
      n_checks++;
      if (s_rdy !== 4'b0000 || s_conf !== 1'b0 || pkt_o !== held) begin
        n_errors++; $display("FAIL bp_hold got rdy=%b conf=%b pkt=%h want rdy=0000 pkt=%h",
                             s_rdy, s_conf, pkt_o, held);
      end
    end
    l2rdy = 1'b1;
    do_cycle();
    n_checks++;
    if (s_rdy !== 4'b1000) begin
      n_errors++; $display("FAIL bp_release_grant got=%b want=1000", s_rdy);
    end
    n_checks++;
    if (core_of(pkt_o) !== 4'd3 || pkt_o !== m_out) begin
      n_errors++; $display("FAIL bp_release_pkt got=%h want=%h", pkt_o, m_out);
    end
  endtask

  task automatic test_single();
    l2rdy = 1'b1;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < N; i++) req[i] = mk(i == 1);
      do_cycle();
      n_checks++;
      if (s_rdy !== 4'b0010 || s_conf !== 1'b0) begin
        n_errors++; $display("FAIL single_grant got=%b/%b want=0010/0", s_rdy, s_conf);
      end
      n_checks++;
      if (pkt_o[VB] !== 1'b1 || core_of(pkt_o) !== 4'd1 || pkt_o !== m_out) begin
        n_errors++; $display("FAIL single_pkt got=%h want=%h", pkt_o, m_out);
      end
    end
  endtask

  task automatic test_sparse();
    l2rdy = 1'b1;
    for (int i = 0; i < N; i++) req[i] = mk(i == 3);
    do_cycle();
    n_checks++;
    if (pkt_o[VB] !== 1'b1 || core_of(pkt_o) !== 4'd3 || pkt_o !== m_out) begin
      n_errors++; $display("FAIL sparse_core3 got=%h want=%h", pkt_o, m_out);
    end
    for (int i = 0; i < N; i++) req[i] = mk(i == 0);
    do_cycle();
    n_checks++;
    if (pkt_o[VB] !== 1'b1 || core_of(pkt_o) !== 4'd0 || pkt_o !== m_out) begin
      n_errors++; $display("FAIL sparse_core0 got=%h want=%h", pkt_o, m_out);
    end
    for (int i = 0; i < N; i++) req[i] = mk(1'b0);
    do_cycle();
    n_checks++;
    if (pkt_o[VB] !== 1'b0 || s_rdy !== 4'b0000) begin
      n_errors++; $display("FAIL sparse_idle got valid=%b rdy=%b want 0/0000", pkt_o[VB], s_rdy);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] granted;
    granted = '1;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < N; i++) begin
        if (granted[i] || !req[i][VB]) req[i] = mk(1'($urandom_range(0, 1)));
      end
      l2rdy = ($urandom_range(0, 3) != 0);
      do_cycle();
      granted = e_rdy;
      n_checks++;
      if (s_rdy !== e_rdy || s_conf !== e_conf) begin
        n_errors++; $display("FAIL random_grant cyc=%0d got=%b/%b want=%b/%b",
                             n, s_rdy, s_conf, e_rdy, e_conf);
      end
      n_checks++;
      if (pkt_o[VB] !== m_out[VB] || (m_out[VB] && pkt_o !== m_out)) begin
        n_errors++; $display("FAIL random_pkt cyc=%0d got=%h want=%h", n, pkt_o, m_out);
      end
    end
  endtask

  task automatic test_mid_reset();
    l2rdy = 1'b1;
    for (int i = 0; i < N; i++) req[i] = mk(i == 1);
    do_cycle();
    l2rdy = 1'b0;
    for (int i = 0; i < N; i++) req[i] = mk(1'b1);
    do_cycle();
    n_checks++;
    if (pkt_o[VB] !== 1'b1) begin
      n_errors++; $display("FAIL midrst_setup got valid=%b want=1", pkt_o[VB]);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (pkt_o[VB] !== 1'b0 || rdy_o !== 4'b0000) begin
      n_errors++; $display("FAIL midrst_async got valid=%b rdy=%b want 0/0000", pkt_o[VB], rdy_o);
    end
    l2rdy = 1'b1;
    do_cycle();
    rst_n = 1'b1;
    do_cycle();
    n_checks++;
    if (s_rdy !== 4'b0001 || core_of(pkt_o) !== 4'd0 || pkt_o !== m_out) begin
      n_errors++; $display("FAIL midrst_priority got rdy=%b pkt=%h want rdy=0001 pkt=%h",
                           s_rdy, pkt_o, m_out);
    end
  endtask

  initial begin
    m_out  = '0;
    m_last = N - 1;
    rst_n  = 1'b0;
    l2rdy  = 1'b0;
    req    = '0;
    test_reset();
    test_contention();
    test_backpressure();
    test_single();
    test_sparse();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
